// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: oversamples an idle-high serial line and drives the downstream
// shift register's clear / shift-enable / data. Optional parity bit with SERIAL_PARITY_EN.
module serial_frame_ctrl #(
    parameter int unsigned FRAME_BITS   = 10,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic sclr_n,
    input  logic rxd,
    output logic sr_clr,
    output logic shen,
    output logic serin,
    output logic busy,
    output logic frame_valid,
`ifdef SERIAL_PARITY_EN
    output logic parity_err,
`endif
    output logic framing_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

`ifdef SERIAL_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par;
    logic par_nxt;
    logic parity_err_d;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [BW-1:0] bitcnt;
    logic [BW-1:0] bitcnt_nxt;
    logic          sync1;
    logic          rxd_s;
    logic          bit_end;
    logic          sr_clr_d;
    logic          shen_d;
    logic          serin_d;
    logic          busy_d;
    logic          frame_valid_d;
    logic          framing_err_d;

    assign bit_end = (cnt == BIT_LAST);

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
`ifdef SERIAL_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bitcnt <= bitcnt_nxt;
`ifdef SERIAL_PARITY_EN
            par    <= par_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bitcnt_nxt = bitcnt;
`ifdef SERIAL_PARITY_EN
        par_nxt    = par;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxd_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt    = '0;
                    bitcnt_nxt = '0;
`ifdef SERIAL_PARITY_EN
                    par_nxt    = 1'b0;
`endif
                    state_nxt  = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt    = '0;
                    bitcnt_nxt = bitcnt + BW'(1);
`ifdef SERIAL_PARITY_EN
                    par_nxt    = par ^ rxd_s;
`endif
                    if (bitcnt == LAST_DATA) state_nxt = AFTER_DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
`ifdef SERIAL_PARITY_EN
                    par_nxt   = par ^ rxd_s;
`endif
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; every output is registered one cycle later
    always_comb begin
        sr_clr_d      = 1'b0;
        shen_d        = 1'b0;
        serin_d       = serin;
        busy_d        = (state_nxt != IDLE);
        frame_valid_d = 1'b0;
        framing_err_d = 1'b0;
`ifdef SERIAL_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        case (state)
            START: sr_clr_d = (cnt == HALF_LAST) && !rxd_s;
            DATA: begin
                if (bit_end) begin
                    shen_d  = 1'b1;
                    serin_d = rxd_s;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_valid_d = rxd_s;
                    framing_err_d = !rxd_s;
`ifdef SERIAL_PARITY_EN
                    parity_err_d  = par;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            sr_clr      <= 1'b0;
            shen        <= 1'b0;
            serin       <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            framing_err <= 1'b0;
`ifdef SERIAL_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            sr_clr      <= sr_clr_d;
            shen        <= shen_d;
            serin       <= serin_d;
            busy        <= busy_d;
            frame_valid <= frame_valid_d;
            framing_err <= framing_err_d;
`ifdef SERIAL_PARITY_EN
            parity_err  <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench for serial_frame_ctrl: stimulus pushes expected events, a monitor pops them.
module tb_serial_frame_ctrl;

    localparam int FB  = 10;
    localparam int CPB = 4;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int K_CLR  = 0;
    localparam int K_SHEN = 1;
    localparam int K_FV   = 2;
    localparam int K_FE   = 3;

    typedef struct {
        int          kind;
        logic        val;
        int          gap;
        logic [FB-1:0] sr;
        logic        perr;
    } exp_t;

    logic clk;
    logic sclr_n;
    logic rxd;
    logic sr_clr;
    logic shen;
    logic serin;
    logic busy;
    logic frame_valid;
    logic framing_err;
    logic parity_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_cyc = 0;
    int shen_total = 0;
    logic [FB-1:0] model = '0;
    exp_t q[$];

    serial_frame_ctrl #(.FRAME_BITS(FB), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .sclr_n      (sclr_n),
        .rxd         (rxd),
        .sr_clr      (sr_clr),
        .shen        (shen),
        .serin       (serin),
        .busy        (busy),
        .frame_valid (frame_valid),
`ifdef SERIAL_PARITY_EN
        .parity_err  (parity_err),
`endif
        .framing_err (framing_err)
    );

`ifndef SERIAL_PARITY_EN
    assign parity_err = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input int kind, input logic val, input int gap,
                                 input logic [FB-1:0] sr, input logic perr);
        exp_t e;
        e.kind = kind; e.val = val; e.gap = gap; e.sr = sr; e.perr = perr;
        q.push_back(e);
    endfunction

    function automatic void expect_frame(input logic [FB-1:0] d, input logic stop, input logic perr);
        push(K_CLR, 1'b0, 0, '0, 1'b0);
        for (int i = FB - 1; i >= 0; i--) push(K_SHEN, d[i], CPB, '0, 1'b0);
        push(stop ? K_FV : K_FE, 1'b0, CPB * (1 + PAR), d, perr);
    endfunction

    // Monitor: samples just after each rising edge and checks against the queue
    initial begin
        exp_t e;
        int   n_ev;
        int   kind;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sr_clr || shen || frame_valid || framing_err) begin
                n_ev = int'(sr_clr) + int'(shen) + int'(frame_valid) + int'(framing_err);
                kind = sr_clr ? K_CLR : shen ? K_SHEN : frame_valid ? K_FV : K_FE;
                if (n_ev != 1) chk("single_event", n_ev, 1);
                if (sr_clr) model = '0;
                if (shen) begin
                    model = {model[FB-2:0], serin};
                    shen_total++;
                end
                if (q.size() == 0) begin
                    chk("unexpected_event", kind, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (e.kind == K_SHEN) chk("serin", int'(serin), int'(e.val));
                    if (e.gap != 0) chk("event_gap", cyc - last_cyc, e.gap);
                    if (e.kind >= K_FV) begin
                        chk("shift_reg_out", int'(model), int'(e.sr));
                        chk("parity_err", int'(parity_err), int'(e.perr));
                    end
                end
                last_cyc = cyc;
            end else if (parity_err) begin
                chk("stray_parity_err", 1, 0);
            end
        end
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [FB-1:0] d, input logic stop, input logic pbit);
        drive_bit(1'b0);
        for (int i = FB - 1; i >= 0; i--) drive_bit(d[i]);
        if (PAR != 0) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sr_clr"}, int'(sr_clr), 0);
        chk({tag, "_shen"}, int'(shen), 0);
        chk({tag, "_serin"}, int'(serin), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_valid"}, int'(frame_valid), 0);
        chk({tag, "_framing_err"}, int'(framing_err), 0);
        chk({tag, "_parity_err"}, int'(parity_err), 0);
    endtask

    initial begin
        logic [FB-1:0] d;
        logic          seen_busy;
        int            base;

        // Reset held with the line low
        sclr_n = 1'b0;
        rxd    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("reset");
        end
        rxd    = 1'b1;
        sclr_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
        end

        // Good frame
        d = 10'b1011001110;
        expect_frame(d, 1'b1, 1'b0);
        send_frame(d, 1'b1, ^d);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("post_frame_busy", int'(busy), 0);

        // One-cycle glitch on the line
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        seen_busy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_busy = seen_busy | busy;
        end
        chk("glitch_busy_seen", int'(seen_busy), 1);
        chk("glitch_busy_end", int'(busy), 0);

        // Bad stop bit followed immediately by a new start
        d = 10'b0000000001;
        expect_frame(d, 1'b0, 1'b0);
        send_frame(d, 1'b0, ^d);
        d = 10'b0110100101;
        expect_frame(d, 1'b1, 1'b0);
        send_frame(d, 1'b1, ^d);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Reset after the fifth shift enable abandons the frame
        d = 10'b1110010011;
        push(K_CLR, 1'b0, 0, '0, 1'b0);
        for (int i = FB - 1; i >= FB - 5; i--) push(K_SHEN, d[i], CPB, '0, 1'b0);
        base = shen_total;
        drive_bit(1'b0);
        for (int i = FB - 1; i >= FB - 5; i--) drive_bit(d[i]);
        for (int k = 0; k < 12 && (shen_total - base) < 5; k++) @(negedge clk);
        chk("mid_reset_shen_count", shen_total - base, 5);
        chk("mid_frame_busy", int'(busy), 1);
        sclr_n = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        sclr_n = 1'b1;
        rxd    = 1'b1;
        repeat (12) @(negedge clk);
        chk("after_reset_busy", int'(busy), 0);
        d = 10'b0101110001;
        expect_frame(d, 1'b1, 1'b0);
        send_frame(d, 1'b1, ^d);
        drive_bit(1'b1);
        drive_bit(1'b1);

`ifdef SERIAL_PARITY_EN
        d = 10'b1100000000;
        expect_frame(d, 1'b1, 1'b1);
        send_frame(d, 1'b1, 1'b1);
        drive_bit(1'b1);
        expect_frame(d, 1'b1, 1'b0);
        send_frame(d, 1'b1, 1'b0);
        drive_bit(1'b1);
`endif

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
